shift_add_multiplier: RTL and testbench

Multi-cycle unsigned multiplier for the datapath. Consumes the 16-bit lookahead adder as its iteration adder: drives the adder's A/B/cin every cycle and captures its sum/carry-out. Performs one shift-add step per cycle and returns a 2N-bit product with a start/done handshake.

---
 rtl/mult_pkg.sv | 13 +
 rtl/lookahead_adder.sv | 49 ++++
 rtl/mult_unit.sv | 47 ++++
 rtl/shift_add_multiplier.sv | 89 ++++++++
 tb/tb_shift_add_multiplier.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier and its integration wrapper.
package mult_pkg;

  localparam int N_DEF  = 16;
  localparam int CW_DEF = $clog2(N_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lookahead_adder.sv
// W-bit adder built from 4-bit groups with group generate/propagate lookahead.
// The carry into each group comes from the lookahead chain; bits inside a group ripple.
module lookahead_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int NG = W / 4;

  always_comb begin
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] c;
    logic [NG:0]  gc;
    logic         gg;
    logic         gp;
    // NOTE: every variable gets a value before any branch or loop reads it, so no latch is inferred.
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    gc    = '0;
    gc[0] = cin;
    gg    = 1'b0;
    gp    = 1'b1;
    for (int k = 0; k < NG; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        gg = g[4*k+j] | (p[4*k+j] & gg);
        gp = gp & p[4*k+j];
      end
      gc[k+1] = gg | (gp & gc[k]);
    end
    for (int k = 0; k < NG; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    s    = p ^ c;
    cout = gc[NG];
  end

endmodule

// File: rtl/mult_unit.sv
// Integration wrapper: the shift-add multiplier iterating through the lookahead adder.
module mult_unit
  import mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_s;
  logic         add_cout;

  shift_add_multiplier #(.N(N)) u_mult (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  lookahead_adder #(.W(N)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-add multiplier; one add-and-shift step per clock through
// an external N-bit adder, fixed latency of N+1 cycles from accept to done.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  output logic           add_cin,
  input  logic [N-1:0]   add_s,
  input  logic           add_cout
);

  state_t         state, state_nxt;
  logic [N-1:0]   acc;
  logic [N-1:0]   mreg;
  logic [N-1:0]   mc;
  logic [CW-1:0]  count;
  logic           last_iter;
  logic [2*N-1:0] shifted;

  assign last_iter = (count == CW'(N - 1));
  // {cout, sum, mreg} >> 1: the adder carry lands in the accumulator MSB, mreg[0] drops out.
  assign shifted   = {add_cout, add_s, mreg[N-1:1]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a = acc;
      add_b = mreg[0] ? mc : '0;
    end
  end

  // NOTE: the datapath registers are reset too, so a reset mid-run leaves no stale partial product.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      acc     <= '0;
      mreg    <= '0;
      mc      <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mc    <= mcand;
            mreg  <= mplier;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          {acc, mreg} <= shifted;
          count       <= count + CW'(1);
          if (last_iter) product <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench: multiplier alone against a behavioural adder, plus the mult_unit wrapper end to end,
// both driven identically; products come from a scoreboard filled at accept time.
module tb_shift_add_multiplier;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplier;

  logic        busy, done;
  logic [31:0] product;
  logic [15:0] add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic [16:0] model_sum;

  logic        u_busy, u_done;
  logic [31:0] u_product;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] last_product = '0;

  assign model_sum           = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
  assign {add_cout, add_s}   = model_sum;

  shift_add_multiplier #(.N(16), .CW(5)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  mult_unit #(.N(16)) u_unit (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (u_busy),
    .done    (u_done),
    .product (u_product)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge (edge 0).
  // poke: pulse start with other operands in cycles 5 and 17, both of which must be ignored.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit poke);
    logic [31:0] exp;
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    sb.push_back({16'b0, a} * {16'b0, b});
    @(negedge Clk);
    start  = 1'b0;
    mcand  = 16'($urandom);
    mplier = 16'($urandom);
    check("hold_on_accept", product, last_product);
    check("u_hold_on_accept", u_product, last_product);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      if (cyc > 1) @(negedge Clk);
      check("run_flags", {busy, done, u_busy, u_done}, 4'b1010);
      check("add_cin", add_cin, 1'b0);
      if (b == 16'h0) check("add_b_zero", add_b, 16'h0);
      if (poke && cyc == 5) begin
        start  = 1'b1;
        mcand  = 16'hAAAA;
        mplier = 16'h5555;
      end
      if (poke && cyc == 6) start = 1'b0;
    end
    @(negedge Clk);
    check("done_flags", {busy, done, u_busy, u_done}, 4'b0101);
    if (sb.size() == 0) begin
      check("sb_empty", 1'b1, 1'b0);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    check("product", product, exp);
    check("u_product", u_product, exp);
    last_product = exp;
    if (poke) begin
      start  = 1'b1;
      mcand  = 16'h0F0F;
      mplier = 16'h00FF;
    end
    @(negedge Clk);
    check("idle_flags", {busy, done, u_busy, u_done}, 4'b0000);
    check("product_hold", product, exp);
    check("idle_add", {add_a, add_b}, 32'h0);
    start = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    start   = 1'b0;
    mcand   = '0;
    mplier  = '0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    check("rst_product", product, 32'h0);
    check("rst_u_product", u_product, 32'h0);
    check("rst_flags", {busy, done, u_busy, u_done}, 4'b0000);
    check("rst_add", {add_a, add_b}, 32'h0);
    @(negedge Clk);

    run_op(16'd3, 16'd5, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    run_op(16'h1234, 16'h0000, 1'b0);
    run_op(16'h00C3, 16'h0101, 1'b1);
    run_op(16'h2222, 16'h3333, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0);
    end
    run_op(16'h8000, 16'h0001, 1'b0);

    // Reset during RUN: partial 7*9 is discarded, no done pulse follows.
    mcand  = 16'd7;
    mplier = 16'd9;
    start  = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int cyc = 2; cyc <= 8; cyc++) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check("midrst_flags", {busy, done, u_busy, u_done}, 4'b0000);
    check("midrst_product", product, 32'h0);
    check("midrst_u_product", u_product, 32'h0);
    last_product = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("midrst_no_done", {done, u_done}, 2'b00);
    end
    run_op(16'd7, 16'd9, 1'b0);
    check("final_product", product, 32'h3F);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
